// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative significand multiply / divide for the FPU datapath.
//   Multiply: radix-2 shift-add, one multiplier bit per cycle (SIG_W cycles).
//   Divide:   radix-2 restoring, one quotient bit per cycle (SIG_W+2 cycles).
//   Results are unrounded; the rounder downstream consumes fq/eq/sq.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   fdiv                  1 = fa/fb, 0 = fa*fb
//   sa, sb, fa, fb        signs and normalised significands (hidden bit at MSB)
//   ea, eb, lza, lzb      biased exponents and leading-zero corrections
//   out_valid / out_ready result handshake; outputs hold while out_valid
//   fq                    {2 integer bits, SIG_W+1 fraction bits, sticky}
//   eq                    two's-complement biased exponent, EXP_W+2 bits
//   sq                    result sign
//   dbz                   divide by zero (fb == 0 on a divide)
//
// Build option: MULDIV_ZERO_SKIP_EN -- multiply with a zero operand, or divide
// with fa == 0 and fb != 0, bypasses the iteration and completes in one cycle.
module muldiv_iter #(
  parameter int SIG_W = 53,
  parameter int EXP_W = 11,
  parameter int BIAS  = 1023,
  parameter int LZ_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               fdiv,
  input  logic               sa,
  input  logic               sb,
  input  logic [SIG_W-1:0]   fa,
  input  logic [SIG_W-1:0]   fb,
  input  logic [EXP_W-1:0]   ea,
  input  logic [EXP_W-1:0]   eb,
  input  logic [LZ_W-1:0]    lza,
  input  logic [LZ_W-1:0]    lzb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIG_W+3:0]   fq,
  output logic [EXP_W+1:0]   eq,
  output logic               sq,
  output logic               dbz
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * SIG_W;
  localparam int CW = $clog2(SIG_W + 2);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [PW-1:0]    mcand, prod, prod_add;
  logic [SIG_W-1:0] mplier, dvs;
  logic [SIG_W:0]   rem, rem_nx;
  logic [SIG_W:0]   q;        // quotient bits already produced
  logic [SIG_W+1:0] diff;     // one extra bit carries the trial sign
  logic             take, last, skip, q_bit, div0;
  logic [EW-1:0]    ea_x, eb_x, lza_x, lzb_x, bias_x, e_mul, e_div;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign take      = in_valid && in_ready;
  assign last      = (cnt == '0);
  assign div0      = fdiv && (fb == '0);

`ifdef MULDIV_ZERO_SKIP_EN
  assign skip = fdiv ? ((fa == '0) && (fb != '0)) : ((fa == '0) || (fb == '0));
`else
  assign skip = 1'b0;
`endif

  // Exponents are widened by two bits so under/overflow stays representable.
  assign ea_x   = EW'(ea);
  assign eb_x   = EW'(eb);
  assign lza_x  = EW'(lza);
  assign lzb_x  = EW'(lzb);
  assign bias_x = EW'(BIAS);
  assign e_mul  = (ea_x - lza_x) + (eb_x - lzb_x) - bias_x;
  assign e_div  = (ea_x - lza_x) - (eb_x - lzb_x) + bias_x;

  assign prod_add = mplier[0] ? (prod + mcand) : prod;
  assign diff     = {1'b0, rem} - {2'b00, dvs};
  assign q_bit    = ~diff[SIG_W+1];
  assign rem_nx   = q_bit ? diff[SIG_W:0] : rem;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (take) begin
        if (div0 || skip) state_nx = DONE;
        else if (fdiv)    state_nx = DIV;
        else              state_nx = MUL;
      end
      MUL:     if (last) state_nx = DONE;
      DIV:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; mcand <= '0; prod <= '0; mplier <= '0; dvs <= '0;
      rem <= '0; q <= '0; fq <= '0; eq <= '0; sq <= 1'b0; dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          sq     <= sa ^ sb;
          eq     <= fdiv ? e_div : e_mul;
          dbz    <= div0;
          fq     <= '0;   // final value for the bypass paths
          mcand  <= PW'(fa);
          mplier <= fb;
          prod   <= '0;
          rem    <= {1'b0, fa};
          dvs    <= fb;
          q      <= '0;
          cnt    <= fdiv ? CW'(SIG_W + 1) : CW'(SIG_W - 1);
        end
        MUL: begin
          prod   <= prod_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (last) fq <= {prod_add[PW-1 -: SIG_W+3], |prod_add[SIG_W-4:0]};
        end
        DIV: begin
          // rem < 2*fb always, so the left shift never overflows SIG_W+1 bits
          rem <= rem_nx << 1;
          q   <= {q[SIG_W-1:0], q_bit};
          cnt <= cnt - 1'b1;
          if (last) fq <= {1'b0, q, q_bit, rem_nx != '0};
        end
        DONE: if (out_ready) dbz <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, fdiv, sa, sb;
  logic [52:0] fa, fb;
  logic [10:0] ea, eb;
  logic [5:0]  lza, lzb;
  logic        out_valid, out_ready;
  logic [56:0] fq;
  logic [12:0] eq;
  logic        sq, dbz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic ov_d = 1'b0;

`ifdef MULDIV_ZERO_SKIP_EN
  localparam int ZM = 1, ZD = 1;
`else
  localparam int ZM = 54, ZD = 56;
`endif

  typedef struct {
    logic [56:0] fq;
    logic [12:0] eq;
    logic        sq;
    logic        dbz;
    int          t;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [52:0] ONE  = 53'h10_0000_0000_0000;
  localparam logic [52:0] ONE5 = 53'h18_0000_0000_0000;
  localparam logic [52:0] MAXS = 53'h1F_FFFF_FFFF_FFFF;

  muldiv_iter #(.SIG_W(53), .EXP_W(11), .BIAS(1023), .LZ_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fdiv(fdiv), .sa(sa), .sb(sb), .fa(fa), .fb(fb), .ea(ea), .eb(eb),
    .lza(lza), .lzb(lzb), .out_valid(out_valid), .out_ready(out_ready),
    .fq(fq), .eq(eq), .sq(sq), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (rst) ov_d = 1'b0;
    else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          if (!ov_d) chk("latency", 64'(cyc - sb_q[0].t), 64'(sb_q[0].lat));
          chk("fq", 64'(fq), 64'(sb_q[0].fq));
          chk("eq", 64'(eq), 64'(sb_q[0].eq));
          chk("sq", 64'(sq), 64'(sb_q[0].sq));
          chk("dbz", 64'(dbz), 64'(sb_q[0].dbz));
          chk("in_ready_in_done", 64'(in_ready), 64'd0);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      ov_d = out_valid;
    end
  end

  // Called at posedge+2; returns at posedge+2 just after the accept edge.
  task automatic issue(input logic fd, input logic s_a, input logic s_b,
                       input logic [52:0] a, input logic [52:0] b,
                       input logic [10:0] e_a, input logic [10:0] e_b,
                       input logic [5:0] l_a, input logic [5:0] l_b,
                       input logic [56:0] xfq, input logic [12:0] xeq,
                       input logic xsq, input logic xdbz, input int lat, input bit push);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #2; n++; end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    fdiv = fd; sa = s_a; sb = s_b; fa = a; fb = b;
    ea = e_a; eb = e_b; lza = l_a; lzb = l_b; in_valid = 1'b1;
    e.fq = xfq; e.eq = xeq; e.sq = xsq; e.dbz = xdbz; e.t = cyc; e.lat = lat;
    if (push) sb_q.push_back(e);
    @(posedge clk); #2;
    // scramble the operand bus while busy; must not disturb the result
    in_valid = 1'b0; fdiv = ~fd; sa = ~s_a; sb = ~s_b; fa = ~a; fb = ~b;
    ea = ~e_a; eb = ~e_b; lza = ~l_a; lzb = ~l_b;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(posedge clk); #2; n++; end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; fdiv = 1'b0; sa = 1'b0; sb = 1'b0;
    fa = '0; fb = '0; ea = '0; eb = '0; lza = '0; lzb = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_fq", 64'(fq), 64'd0);
    chk("rst_eq", 64'(eq), 64'd0);
    chk("rst_sq", 64'(sq), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;

    // 1.0 * 1.0
    issue(0, 0, 0, ONE, ONE, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'h080_0000_0000_0000, 13'd1023, 0, 0, 54, 1);
    drain();
    // -1.5 * 1.5 = -2.25
    issue(0, 1, 0, ONE5, ONE5, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'h120_0000_0000_0000, 13'd1023, 1, 0, 54, 1);
    drain();
    // max * max: sticky set, negative exponent 100+50-1023 = -873
    issue(0, 0, 0, MAXS, MAXS, 11'd100, 11'd50, 6'd0, 6'd0,
          57'h1FF_FFFF_FFFF_FFE1, 13'h1C97, 0, 0, 54, 1);
    drain();
    // 1.0 / 1.5 = 0.101010..., inexact
    issue(1, 0, 0, ONE, ONE5, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'h055_5555_5555_5555, 13'd1023, 0, 0, 56, 1);
    drain();
    // 1.5 / 1.5 exact, exponent (1000-1)-(1010-0)+1023 = 1012
    issue(1, 0, 1, ONE5, ONE5, 11'd1000, 11'd1010, 6'd1, 6'd0,
          57'h080_0000_0000_0000, 13'd1012, 1, 0, 56, 1);
    drain();
    // max / 1.0: integer bit set, all fraction bits carried
    issue(1, 0, 0, MAXS, ONE, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'h0FF_FFFF_FFFF_FFF8, 13'd1023, 0, 0, 56, 1);
    drain();
    // divide by zero
    issue(1, 1, 0, ONE, 53'd0, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'd0, 13'd1023, 1, 1, 1, 1);
    drain();
    chk("dbz_cleared", 64'(dbz), 64'd0);
    // normal mul after dbz: (1030-3)+(1000-2)-1023 = 1002
    issue(0, 1, 1, ONE, MAXS, 11'd1030, 11'd1000, 6'd3, 6'd2,
          57'h0FF_FFFF_FFFF_FFF8, 13'd1002, 0, 0, 54, 1);
    drain();
    // zero operands
    issue(0, 0, 1, 53'd0, ONE, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'd0, 13'd1023, 1, 0, ZM, 1);
    drain();
    issue(1, 0, 0, 53'd0, ONE5, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'd0, 13'd1023, 0, 0, ZD, 1);
    drain();

    // back-pressure: hold out_ready low for 10 cycles in DONE
    out_ready = 1'b0;
    issue(0, 0, 0, ONE, ONE, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'h080_0000_0000_0000, 13'd1023, 0, 0, 54, 1);
    for (int n = 0; n < 200 && !out_valid; n++) begin @(posedge clk); #2; end
    chk("hold_reached_done", 64'(out_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    drain();

    // reset during multiply iteration 20: no result may ever appear
    issue(0, 0, 0, ONE5, ONE5, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'd0, 13'd0, 0, 0, 0, 0);
    repeat (19) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    chk("abort_in_ready_in_rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_fq", 64'(fq), 64'd0);
    repeat (70) begin @(posedge clk); #2; end
    chk("abort_no_output", 64'(out_valid), 64'd0);

    // normal operation after the abort
    issue(0, 0, 0, ONE, ONE, 11'd1023, 11'd1023, 6'd0, 6'd0,
          57'h080_0000_0000_0000, 13'd1023, 0, 0, 54, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
